// File: rtl/mult_fu_pipe_if.sv
// Issue-FIFO-to-multiplier and multiplier-to-CDB signal bundle.
// The master side feeds operands and stall/squash; the slave side is the unit.
interface mult_fu_pipe_if #(
    parameter int XLEN  = 32,
    parameter int PR_W  = 6,
    parameter int ROB_W = 5
);
    logic             in_valid;
    logic [1:0]       in_op;
    logic [XLEN-1:0]  in_r1_value;
    logic [XLEN-1:0]  in_r2_value;
    logic [PR_W-1:0]  in_dest_pr;
    logic [ROB_W-1:0] in_rob_entry;
    logic             fu_ready;
    logic             squash;
    logic             cdb_stall;
    logic             out_valid;
    logic [XLEN-1:0]  out_result;
    logic [PR_W-1:0]  out_dest_pr;
    logic [ROB_W-1:0] out_rob_entry;

    modport master (
        output in_valid, in_op, in_r1_value, in_r2_value,
        output in_dest_pr, in_rob_entry, squash, cdb_stall,
        input  fu_ready, out_valid, out_result,
        input  out_dest_pr, out_rob_entry
    );

    modport slave (
        input  in_valid, in_op, in_r1_value, in_r2_value,
        input  in_dest_pr, in_rob_entry, squash, cdb_stall,
        output fu_ready, out_valid, out_result,
        output out_dest_pr, out_rob_entry
    );
endinterface

// File: rtl/mult_fu_pipe.sv
// Pipelined RV32M multiply unit: folds XLEN/STAGES multiplier bits per stage,
// freezes wholesale while the CDB stalls a valid result.
module mult_fu_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int PR_W   = 6,
    parameter int ROB_W  = 5
) (
    input logic            clock,
    input logic            reset,
    mult_fu_pipe_if.slave  bus
);
    localparam int C = XLEN / STAGES;
    localparam int W = 2 * XLEN;

    typedef struct packed {
        logic             vld;
        logic [1:0]       op;
        logic [PR_W-1:0]  pr;
        logic [ROB_W-1:0] rob;
        logic [W-1:0]     mcand;
        logic [W-1:0]     mplier;
        logic [W-1:0]     sum;
    } stage_t;

    typedef struct packed {
        logic             vld;
        logic [XLEN-1:0]  res;
        logic [PR_W-1:0]  pr;
        logic [ROB_W-1:0] rob;
    } out_t;

    logic   hold;
    logic   s1;
    logic   s2;
    stage_t prep;
    stage_t lsrc;
    logic [W-1:0] prod;
    out_t   oq;

    // rs1 is signed unless MULHU; rs2 is signed only for MUL/MULH
    assign s1 = bus.in_op != 2'b11;
    assign s2 = ~bus.in_op[1];

    always_comb begin
        prep        = '0;
        prep.vld    = bus.in_valid;
        prep.op     = bus.in_op;
        prep.pr     = bus.in_dest_pr;
        prep.rob    = bus.in_rob_entry;
        prep.mcand  = {{XLEN{s1 & bus.in_r1_value[XLEN-1]}}, bus.in_r1_value};
        prep.mplier = {{XLEN{s2 & bus.in_r2_value[XLEN-1]}}, bus.in_r2_value};
    end

    for (genvar k = 0; k < STAGES - 1; k++) begin : g_mid
        stage_t       src;
        stage_t       nxt;
        stage_t       q;
        logic [W-1:0] pp;

        if (k == 0) begin : g_first
            assign src = prep;
        end else begin : g_next
            assign src = g_mid[k-1].q;
        end

        always_comb begin
            nxt        = src;
            pp         = src.mcand * {{(W-C){1'b0}}, src.mplier[C-1:0]};
            nxt.sum    = src.sum + (pp << (k * C));
            nxt.mplier = {{C{src.mplier[W-1]}}, src.mplier[W-1:C]};
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                q <= '0;
            end else begin
                if (!hold)
                    q <= nxt;
                if (bus.squash)
                    q.vld <= 1'b0;
            end
        end
    end

    if (STAGES == 1) begin : g_one
        assign lsrc = prep;
    end else begin : g_many
        assign lsrc = g_mid[STAGES-2].q;
    end

    // Last fold takes the whole sign-extended remainder, making the product exact
    assign prod = lsrc.sum + ((lsrc.mcand * lsrc.mplier) << ((STAGES - 1) * C));

    always_ff @(posedge clock) begin
        if (!reset) begin
            oq <= '0;
        end else begin
            if (!hold) begin
                oq.vld <= lsrc.vld;
                oq.res <= (lsrc.op == 2'b00) ? prod[XLEN-1:0] : prod[W-1:XLEN];
                oq.pr  <= lsrc.pr;
                oq.rob <= lsrc.rob;
            end
            if (bus.squash)
                oq.vld <= 1'b0;
        end
    end

    assign hold              = oq.vld & bus.cdb_stall;
    assign bus.fu_ready      = ~hold;
    assign bus.out_valid     = oq.vld;
    assign bus.out_result    = oq.res;
    assign bus.out_dest_pr   = oq.pr;
    assign bus.out_rob_entry = oq.rob;
endmodule

// File: tb/tb_mult_fu_pipe.sv
// Directed bench for mult_fu_pipe: latency, back-to-back, stall, squash, reset.
// Results are checked in order against a queue of hand-computed values.
module tb_mult_fu_pipe;
    typedef struct {
        logic [31:0] res;
        logic [5:0]  pr;
        logic [4:0]  rob;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   n0;
    exp_t exp_q[$];
    exp_t mon_e;

    mult_fu_pipe_if bus ();

    mult_fu_pipe dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    vec_t b2b[4] = '{
        '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
        '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000},
        '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
        '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE}
    };

    vec_t strm[6] = '{
        '{2'b00, 32'h00000003, 32'h00000005, 32'h0000000F},
        '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA},
        '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF},
        '{2'b10, 32'h80000000, 32'h80000000, 32'hC0000000},
        '{2'b11, 32'h80000000, 32'h00000002, 32'h00000001},
        '{2'b00, 32'h00012345, 32'h00000100, 32'h01234500}
    };

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one packet for a cycle; queues it only if the unit took it
    task automatic send(vec_t v, logic [5:0] pr, logic [4:0] rob);
        logic acc;
        exp_t e;
        bus.in_valid     = 1'b1;
        bus.in_op        = v.op;
        bus.in_r1_value  = v.a;
        bus.in_r2_value  = v.b;
        bus.in_dest_pr   = pr;
        bus.in_rob_entry = rob;
        @(negedge clock);
        acc = bus.fu_ready && !bus.squash && reset;
        tick();
        if (acc) begin
            e.res = v.exp;
            e.pr  = pr;
            e.rob = rob;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clock) begin
        if (reset && bus.out_valid && !bus.cdb_stall) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("spurious", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("res", bus.out_result, mon_e.res);
                check("pr", bus.out_dest_pr, mon_e.pr);
                check("rob", bus.out_rob_entry, mon_e.rob);
            end
        end
    end

    initial begin
        vec_t v;
        bus.in_valid     = 1'b0;
        bus.in_op        = 2'b00;
        bus.in_r1_value  = '0;
        bus.in_r2_value  = '0;
        bus.in_dest_pr   = '0;
        bus.in_rob_entry = '0;
        bus.squash       = 1'b0;
        bus.cdb_stall    = 1'b0;

        tick();
        tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_result", bus.out_result, 0);
        check("rst_pr", bus.out_dest_pr, 0);
        check("rst_rob", bus.out_rob_entry, 0);
        check("rst_ready", bus.fu_ready, 1);
        reset = 1'b1;

        v = '{2'b00, 32'd7, 32'd6, 32'd42};
        send(v, 6'd5, 5'd3);
        bus.in_valid = 1'b0;
        check("lat_t0", bus.out_valid, 0);
        tick();
        check("lat_t1", bus.out_valid, 0);
        tick();
        check("lat_t2", bus.out_valid, 0);
        tick();
        check("lat_t3", bus.out_valid, 1);
        check("lat_res", bus.out_result, 42);
        repeat (3) tick();

        for (int i = 0; i < 4; i++)
            send(b2b[i], 6'(10 + i), 5'(i));
        bus.in_valid = 1'b0;
        check("b2b_v0", bus.out_valid, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("b2b_vn", bus.out_valid, 1);
        end
        tick();
        check("b2b_end", bus.out_valid, 0);
        check("b2b_drain", exp_q.size(), 0);

        n0 = n_out;
        for (int i = 0; i < 4; i++)
            send(strm[i], 6'(20 + i), 5'(8 + i));
        check("st_first", bus.out_valid, 1);
        bus.cdb_stall    = 1'b1;
        bus.in_valid     = 1'b1;
        bus.in_op        = strm[4].op;
        bus.in_r1_value  = strm[4].a;
        bus.in_r2_value  = strm[4].b;
        bus.in_dest_pr   = 6'd24;
        bus.in_rob_entry = 5'd12;
        #1;
        check("st_rdy0", bus.fu_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_valid", bus.out_valid, 1);
            check("st_hold", bus.out_result, strm[0].exp);
            check("st_tag", bus.out_dest_pr, 20);
            check("st_rdy", bus.fu_ready, 0);
        end
        bus.cdb_stall = 1'b0;
        send(strm[4], 6'd24, 5'd12);
        send(strm[5], 6'd25, 5'd13);
        bus.in_valid = 1'b0;
        repeat (8) tick();
        check("st_count", n_out - n0, 6);
        check("st_drain", exp_q.size(), 0);

        n0 = n_out;
        for (int i = 0; i < 3; i++)
            send(b2b[i], 6'(30 + i), 5'(16 + i));
        bus.squash = 1'b1;
        send(b2b[3], 6'd33, 5'd19);
        bus.squash   = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        check("sq_rdy", bus.fu_ready, 1);
        check("sq_valid", bus.out_valid, 0);
        repeat (8) tick();
        check("sq_none", n_out - n0, 0);
        v = '{2'b11, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
        send(v, 6'd40, 5'd20);
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("sq_lat2", bus.out_valid, 0);
        tick();
        check("sq_after", bus.out_valid, 1);
        repeat (3) tick();
        check("sq_drain", exp_q.size(), 0);

        for (int i = 0; i < 4; i++)
            send(strm[i], 6'(50 + i), 5'(24 + i));
        bus.cdb_stall = 1'b1;
        bus.in_valid  = 1'b1;
        reset         = 1'b0;
        tick();
        check("rs_valid", bus.out_valid, 0);
        check("rs_ready", bus.fu_ready, 1);
        check("rs_result", bus.out_result, 0);
        check("rs_pr", bus.out_dest_pr, 0);
        check("rs_rob", bus.out_rob_entry, 0);
        exp_q.delete();
        reset         = 1'b1;
        bus.cdb_stall = 1'b0;
        bus.in_valid  = 1'b0;
        n0 = n_out;
        repeat (8) tick();
        check("rs_none", n_out - n0, 0);
        send(b2b[0], 6'd60, 5'd30);
        bus.in_valid = 1'b0;
        repeat (6) tick();
        check("rs_count", n_out - n0, 1);
        check("rs_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mult_fu_pipe.md
Name: mult_fu_pipe

Overview:
- Pipelined integer multiply functional unit, directly downstream of the issue stage's mult FIFO.
- Accepts one multiply per cycle from a FIFO read port and drives `fu_ready` back to that FIFO.
- Computes RV32M MUL/MULH/MULHSU/MULHU over `STAGES` cycles.
- Presents the result to the complete/CDB stage; the result is held while the CDB stalls.

Parameters:
- XLEN, 32, operand/result width.
- STAGES, 4, pipeline depth; must divide XLEN; each stage folds XLEN/STAGES multiplier bits.
- PR_W, 6, physical register index width.
- ROB_W, 5, ROB entry index width.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-low reset.
- in_valid, input, 1, packet from mult FIFO is valid.
- in_op, input, 2, 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_r1_value, input, XLEN, rs1 operand.
- in_r2_value, input, XLEN, rs2 operand.
- in_dest_pr, input, PR_W, destination physical register.
- in_rob_entry, input, ROB_W, ROB tag.
- fu_ready, output, 1, unit accepts a packet this cycle (FIFO rd_EN for this unit).
- squash, input, 1, mispredict flush.
- cdb_stall, input, 1, complete stage cannot take the output this cycle.
- out_valid, output, 1, result valid.
- out_result, output, XLEN, selected product bits.
- out_dest_pr, output, PR_W, tag of result.
- out_rob_entry, output, ROB_W, tag of result.

Behaviour:
- Reset: when reset==0 at a rising clock edge, all stage valid bits clear.
  - out_valid=0, out_result=0, out_dest_pr=0, out_rob_entry=0, fu_ready=1 after that edge.
  - Reset overrides squash and in_valid.
  - Reset mid-operation discards all in-flight ops; none reappear.
- Operand prep at accept:
  - rs1 is sign-extended to 2*XLEN for MUL/MULH/MULHSU and zero-extended for MULHU.
  - rs2 is sign-extended for MUL/MULH and zero-extended for MULHSU/MULHU.
  - All arithmetic is modulo 2^(2*XLEN).
- Stage k (k=0..STAGES-1) holds valid, op, tags, multiplicand, remaining multiplier and partial sum.
  - It adds (multiplicand × multiplier chunk k) << (k·XLEN/STAGES) to the partial sum.
  - The sign-extended upper half of rs2 is handled by including the extension in the 2*XLEN multiplier; stage STAGES-1 must produce the exact 2*XLEN product.
- Result select:
  - MUL: product[XLEN-1:0].
  - MULH/MULHSU/MULHU: product[2*XLEN-1:XLEN].
- Latency:
  - Packet accepted at edge t (in_valid & fu_ready) gives out_valid=1 in the cycle after edge t+STAGES-1, i.e. STAGES cycles after acceptance, provided there are no stalls.
  - Throughput is 1 per cycle.
- Handshake and stall:
  - hold = out_valid & cdb_stall.
  - fu_ready = ~hold (combinational).
  - When hold=1, every stage register freezes, including empty bubbles, and out_* stay constant.
  - When hold=0, all stages advance; the output is consumed at that edge.
  - in_valid while fu_ready=0 is ignored; the FIFO keeps the packet.
  - cdb_stall while out_valid=0 has no effect.
- Squash:
  - squash=1 at an edge clears every stage valid, including the output stage, even under hold.
  - An in_valid in the same cycle is dropped.
  - fu_ready is 1 the following cycle.
  - Data fields need not clear; out_* data are don't-care whenever out_valid=0.
- Ordering: results exit in acceptance order; no reordering and no bypass.
- Edge cases:
  - MULH of 0x80000000 × 0x80000000 = 0x40000000.
  - MUL of 0xFFFFFFFF × 0xFFFFFFFF = 0x00000001.

Test Plan:
- Reset low 2 cycles, then in_valid op=00, rs1=7, rs2=6 → out_valid=1 exactly 4 cycles after accept, out_result=42, tags echoed.
- Back-to-back 4 ops, one per cycle:
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - Required response: results on 4 consecutive cycles, in order.
- Stream of 6 ops, cdb_stall=1 for 3 cycles once the first result is out → fu_ready=0 for those 3 cycles, out_* constant; after release, remaining results appear in order with none lost or duplicated.
- 3 ops in flight, squash pulsed for 1 cycle together with a new in_valid → no out_valid for any of those 4 ops; the next op accepted after squash completes normally in 4 cycles.
- reset=0 with pipeline full and cdb_stall=1 → next cycle out_valid=0, fu_ready=1, out_result=0; no stale result emerges in the following 8 cycles.
- Random 10k ops with random stalls/squashes vs. a reference model → every non-squashed op's result and tags match, in order.
